// File: rtl/cam_cfg_sequencer_if.sv
// SCCB write-request bus between the camera config sequencer and the SCCB master.
// The master modport is the requester (the sequencer); the slave modport is the
// SCCB master that performs the bus transaction.
interface cam_cfg_sequencer_if;
    logic       valid;  // write request pending
    logic       ready;  // SCCB master can accept the request this cycle
    logic [7:0] addr;   // sensor register address
    logic [7:0] data;   // sensor register value
    logic       done;   // one-cycle pulse: accepted write finished on the bus

    modport master (
        output valid,
        output addr,
        output data,
        input  ready,
        input  done
    );

    modport slave (
        input  valid,
        input  addr,
        input  data,
        output ready,
        output done
    );
endinterface

// File: rtl/cam_cfg_sequencer.sv
// Camera configuration sequencer.
// Walks the config ROM one entry per step and turns each {reg, val} entry into a
// single SCCB register write. Entry 16'hFFF0 inserts a DELAY_CYCLES wait and
// 16'hFFFF ends the table; the address never wraps past 255.
// Optional build macro CFG_SEQ_TIMEOUT_EN adds a per-write watchdog of
// TIMEOUT_CYCLES cycles (SEND + WAIT_DONE) that raises o_error and ends the run.
module cam_cfg_sequencer #(
    parameter logic [23:0] DELAY_CYCLES   = 24'd1_000_000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd200_000
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_start,
    output logic [7:0]                 o_rom_addr,
    input  logic [15:0]                i_rom_data,
    cam_cfg_sequencer_if.master        sccb,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error,
    output logic [7:0]                 o_wr_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_SEND,
        ST_WAIT_DONE,
        ST_DELAY,
        ST_DONE
    } state_t;

    localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;
    localparam logic [15:0] ENTRY_END   = 16'hFFFF;
    // The delay counter counts down to zero inclusive, so N-1 gives N cycles.
    localparam logic [23:0] DELAY_LOAD  = DELAY_CYCLES - 24'd1;

    state_t      state_reg;
    logic [7:0]  rom_addr_reg;
    logic [7:0]  reg_addr_reg;
    logic [7:0]  reg_data_reg;
    logic [7:0]  wr_count_reg;
    logic        valid_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [23:0] delay_cnt_reg;

    logic        last_entry;
    logic        delay_expired;
    logic        accept;

    // The final ROM address ends the run instead of wrapping back to 0.
    assign last_entry    = (rom_addr_reg == 8'hFF);
    assign delay_expired = (delay_cnt_reg == 24'd0);
    assign accept        = valid_reg && sccb.ready;

`ifdef CFG_SEQ_TIMEOUT_EN
    logic [23:0] tout_cnt_reg;
    logic        error_reg;
    logic        tout_hit;

    // Counter value k means k+1 cycles have been spent on this write so far.
    assign tout_hit = (tout_cnt_reg == (TIMEOUT_CYCLES - 24'd1));
    assign o_error  = error_reg;
`else
    // Without the watchdog the timeout length has no effect; it is folded into
    // an otherwise unused net so both builds share one parameter list.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign o_error = 1'b0;
`endif

    // Sequencer FSM: all outputs are registered and updated on state transitions.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_reg     <= ST_IDLE;
            rom_addr_reg  <= 8'd0;
            reg_addr_reg  <= 8'd0;
            reg_data_reg  <= 8'd0;
            wr_count_reg  <= 8'd0;
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            delay_cnt_reg <= 24'd0;
`ifdef CFG_SEQ_TIMEOUT_EN
            tout_cnt_reg  <= 24'd0;
            error_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                // A new run may only be launched from rest.
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        rom_addr_reg <= 8'd0;
                        wr_count_reg <= 8'd0;
                        done_reg     <= 1'b0;
                        busy_reg     <= 1'b1;
`ifdef CFG_SEQ_TIMEOUT_EN
                        error_reg    <= 1'b0;
`endif
                        state_reg    <= ST_FETCH;
                    end
                end

                // Address is held for one cycle while the ROM registers it.
                ST_FETCH: begin
                    state_reg <= ST_DECODE;
                end

                // ROM data for the current address is valid now.
                ST_DECODE: begin
                    if (i_rom_data == ENTRY_END) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else if (i_rom_data == ENTRY_DELAY) begin
                        delay_cnt_reg <= DELAY_LOAD;
                        state_reg     <= ST_DELAY;
                    end else begin
                        reg_addr_reg <= i_rom_data[15:8];
                        reg_data_reg <= i_rom_data[7:0];
                        valid_reg    <= 1'b1;
`ifdef CFG_SEQ_TIMEOUT_EN
                        tout_cnt_reg <= 24'd0;
`endif
                        state_reg    <= ST_SEND;
                    end
                end

                // Request held stable until the SCCB master takes it.
                ST_SEND: begin
`ifdef CFG_SEQ_TIMEOUT_EN
                    tout_cnt_reg <= tout_cnt_reg + 24'd1;
                    if (tout_hit) begin
                        valid_reg <= 1'b0;
                        error_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else
`endif
                    if (accept) begin
                        valid_reg <= 1'b0;
                        state_reg <= ST_WAIT_DONE;
                    end
                end

                // Completion of the accepted write; the count saturates at 255.
                ST_WAIT_DONE: begin
`ifdef CFG_SEQ_TIMEOUT_EN
                    tout_cnt_reg <= tout_cnt_reg + 24'd1;
`endif
                    if (sccb.done) begin
                        if (wr_count_reg != 8'hFF) begin
                            wr_count_reg <= wr_count_reg + 8'd1;
                        end
                        if (last_entry) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            rom_addr_reg <= rom_addr_reg + 8'd1;
                            state_reg    <= ST_FETCH;
                        end
                    end
`ifdef CFG_SEQ_TIMEOUT_EN
                    else if (tout_hit) begin
                        error_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end
`endif
                end

                // Delay entry: exactly DELAY_CYCLES cycles here, then advance.
                ST_DELAY: begin
                    if (delay_expired) begin
                        if (last_entry) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            rom_addr_reg <= rom_addr_reg + 8'd1;
                            state_reg    <= ST_FETCH;
                        end
                    end else begin
                        delay_cnt_reg <= delay_cnt_reg - 24'd1;
                    end
                end

                default: begin
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rom_addr = rom_addr_reg;
    assign o_busy     = busy_reg;
    assign o_done     = done_reg;
    assign o_wr_count = wr_count_reg;
    assign sccb.valid = valid_reg;
    assign sccb.addr  = reg_addr_reg;
    assign sccb.data  = reg_data_reg;

endmodule
